// File: rtl/idea_blk_packer_pkg.sv
// Shared constants and types for the IDEA block packer.
// Pure declarations: no logic, no latency, no flow control.
package idea_pkg;
  localparam int IDEA_BLK_W     = 64;
  localparam int IDEA_KEY_W     = 128;
  localparam int IDEA_BLK_BYTES = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PADB = 2'd2
  } pk_state_t;

  typedef logic [7:0] idea_byte_t;
endpackage

// File: rtl/idea_blk_packer_if.sv
// Byte-in / block-out valid-ready bundle; master is the packer, slave the environment.
// Wires only: no latency; ready/valid semantics are defined by the packer.
interface idea_blk_packer_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic [3:0]  m_nbytes;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_nbytes
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_nbytes
  );
endinterface

// File: rtl/idea_blk_packer_pad_fill.sv
// Fills lanes k..7 of a big-endian block with PKCS#7 bytes (8-k) or zeros.
// Combinational, zero latency; no flow control. k >= 8 passes the block through.
module idea_pad_fill
  import idea_pkg::*;
(
  input  logic [IDEA_BLK_W-1:0] blk_in,
  input  logic [3:0]            k,
  input  logic                  pad_en,
  output logic [IDEA_BLK_W-1:0] blk_out
);

  idea_byte_t pad_byte;

  always_comb begin
    pad_byte = pad_en ? {4'b0000, 4'd8 - k} : 8'h00;
    blk_out  = blk_in;
    for (int i = 0; i < IDEA_BLK_BYTES; i++) begin
      if (4'(i) >= k) blk_out[IDEA_BLK_W-8-8*i +: 8] = pad_byte;
    end
  end

endmodule

// File: rtl/idea_blk_packer.sv
// Packs a byte stream big-endian into 64-bit blocks with PKCS#7 tail padding; holds the IDEA key.
// Block valid one cycle after its last byte; s_ready low while a block waits for m_ready.
module idea_blk_packer
  import idea_pkg::*;
#(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  idea_blk_packer_if.master     bus,
  input  logic                  key_load,
  input  logic [IDEA_KEY_W-1:0] key_in,
  output logic [IDEA_KEY_W-1:0] key_out,
  output logic                  key_err,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam logic [IDEA_BLK_W-1:0] PAD_BLK = {IDEA_BLK_BYTES{8'h08}};

  pk_state_t             state_q;
  logic [2:0]            idx_q;
  logic [IDEA_BLK_W-1:0] lanes_q;
  logic [3:0]            nbytes_q;
  logic                  last_q;
  logic                  pad_pend_q;
  logic [IDEA_KEY_W-1:0] key_q;
  logic                  key_err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDEA_BLK_W-1:0] fill_blk;
  logic [5:0]            lane_lsb;
  logic                  full8;

  // Lane 0 sits in the top byte, so the lsb of lane idx is 8*(7-idx).
  assign lane_lsb = {~idx_q, 3'b000};
  assign full8    = (idx_q == 3'd7);

  idea_pad_fill u_pad_fill (
    .blk_in  (lanes_q),
    .k       (nbytes_q),
    .pad_en  (PAD_EN),
    .blk_out (fill_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      idx_q      <= '0;
      lanes_q    <= '0;
      nbytes_q   <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      key_q      <= '0;
      key_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      key_err_q <= 1'b0;
      if (key_load) begin
        if (state_q == FILL && idx_q == 3'd0) key_q <= key_in;
        else key_err_q <= 1'b1;
      end

      case (state_q)
        FILL: begin
          if (bus.s_valid) begin
            lanes_q[lane_lsb +: 8] <= bus.s_data;
            if (full8 || bus.s_last) begin
              state_q    <= HOLD;
              idx_q      <= '0;
              nbytes_q   <= {1'b0, idx_q} + 4'd1;
              // A full final block under padding defers m_last to the pad block.
              last_q     <= bus.s_last & ~(full8 & PAD_EN);
              pad_pend_q <= bus.s_last & full8 & PAD_EN;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            cnt_q      <= cnt_q + CNT_W'(1);
            state_q    <= pad_pend_q ? PADB : FILL;
            pad_pend_q <= 1'b0;
          end
        end
        PADB: begin
          if (bus.m_ready) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_comb begin
    bus.m_data   = '0;
    bus.m_last   = 1'b0;
    bus.m_nbytes = '0;
    case (state_q)
      HOLD: begin
        bus.m_data   = fill_blk;
        bus.m_last   = last_q;
        bus.m_nbytes = nbytes_q;
      end
      PADB: begin
        bus.m_data   = PAD_BLK;
        bus.m_last   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_ready = (state_q == FILL);
  assign bus.m_valid = (state_q == HOLD) || (state_q == PADB);
  assign key_out     = key_q;
  assign key_err     = key_err_q;
  assign blk_cnt     = cnt_q;

endmodule
